hdmi_period_tracker: RTL and testbench
======================================

HDMI_PERIOD_TRACKER -- requirements
Module: hdmi_period_tracker

Interface
REQ-001 SHALL have parameter PRE_LEN, default 8, the number of consecutive preamble cycles required to arm a guard-band check.
REQ-002 SHALL have parameter CNT_W, default 12, the width of all pixel and line counters.
REQ-003 SHALL have one clock, `pclk` (input, 1), the pixel clock; all logic is on its rising edge.
REQ-004 SHALL have reset `reset_n` (input, 1), asynchronous and active-low.
REQ-005 SHALL have `all_rdy` (input, 1): all three TMDS channel decoders are bonded and ready.
REQ-006 SHALL have `de0`, `de1`, `de2` (input, 1 each): per-channel data-enable from the decoders (ch0 = blue, ch1 = green, ch2 = red).
REQ-007 SHALL have `c0_0`, `c1_0` (input, 1 each): ch0 control bits, carrying HSYNC and VSYNC.
REQ-008 SHALL have `c0_1`, `c1_1`, `c0_2`, `c1_2` (input, 1 each): the CTL0, CTL1, CTL2 and CTL3 bits.
REQ-009 SHALL have `ctl_vld1`, `ctl_vld2` (input, 1 each): a control token was decoded on ch1 / ch2.
REQ-010 SHALL have `vgb0` (input, 1): video guard band seen on ch0.
REQ-011 SHALL have `dgb1`, `dgb2` (input, 1 each): data guard band seen on ch1 / ch2.
REQ-012 SHALL have `hsync`, `vsync` (output, 1 each): registered copies of `c0_0` / `c1_0`, updated only while `de0` = 0.
REQ-013 SHALL have `vid_active` (output, 1): the tracker is in the video data period.
REQ-014 SHALL have `di_active` (output, 1): the tracker is in the data island period.
REQ-015 SHALL have `hdmi_mode` (output, 1): a valid data island has been seen since the last reset or loss of ready.
REQ-016 SHALL have `frame_start` (output, 1): a one-cycle pulse on the VSYNC rising edge.
REQ-017 SHALL have `h_active` and `v_active` (output, CNT_W each): the latched pixels per line and active lines per frame.
REQ-018 SHALL have `err` (output, 1): a one-cycle pulse on any protocol violation.

Function
REQ-019 SHALL register every output, so each reflects the inputs one pclk after they are sampled.
REQ-020 SHALL define a preamble cycle as `ctl_vld1` & `ctl_vld2` & (CTL3..CTL0 = 0001 for video, or 0101 for island); the preamble counter saturates at PRE_LEN.
REQ-021 SHALL implement the states CTRL, PRE_V, PRE_D, VGB, VIDEO, DGB_L, ISLAND and DGB_T.
REQ-022 CTRL -> PRE_V or PRE_D on the first video or island preamble cycle; a pattern change within the preamble restarts the count in the matching state; a non-preamble control token returns to CTRL.
REQ-023 PRE_V -> VGB when `vgb0` is seen with count >= PRE_LEN; `vgb0` with count < PRE_LEN SHALL pulse `err` and go to CTRL.
REQ-024 PRE_D -> DGB_L when `dgb1` & `dgb2` are seen with count >= PRE_LEN; too early SHALL pulse `err` and go to CTRL.
REQ-025 VGB and DGB_L SHALL each last exactly 2 cycles; a third guard-band cycle, or a missing second one, SHALL pulse `err` and go to CTRL.
REQ-026 VGB -> VIDEO when `de0` & `de1` & `de2`.
REQ-027 In VIDEO, the pixel counter SHALL increment per cycle, saturating at 2^CNT_W-1.
REQ-028 On the first cycle any `de` is low in VIDEO: latch `h_active` = pixel count, increment the saturating line counter, clear the pixel counter, and go to CTRL.
REQ-029 In ISLAND, the island-length counter SHALL increment per cycle; `dgb1` & `dgb2` -> DGB_T.
REQ-030 On entering DGB_T, an island length that is not a nonzero multiple of 32 SHALL pulse `err`; otherwise `hdmi_mode` is set.
REQ-031 DGB_T SHALL last 2 cycles and then go to CTRL; a deviation pulses `err` and goes to CTRL.
REQ-032 On the `vsync` rising edge: pulse `frame_start`, latch `v_active` = line count, and clear the line count; the edge is evaluated in any state.
REQ-033 `vid_active` = (state == VIDEO) and `di_active` = (state == ISLAND), both registered.
REQ-034 `all_rdy` = 0 SHALL, on the next edge: force CTRL, clear the counters and `hdmi_mode`, and hold `hsync`, `vsync`, `h_active` and `v_active`; `err` is not asserted.
REQ-035 If `frame_start` and a line end occur in the same cycle, the line increment SHALL be counted before `v_active` is latched, and the line counter then restarts at 0.

Reset
REQ-036 `reset_n` low SHALL asynchronously set state = CTRL, all counters = 0, and every output = 0.
REQ-037 Reset asserted mid-line SHALL discard the partial counts, with no `err` pulse after release.

Verification
REQ-038 Video sequence (8 preamble cycles 0001, then 2 `vgb0`, then 1280 de cycles, then ctl) -> `vid_active` high for 1280 cycles and `h_active` = 1280, with no `err`.
REQ-039 A frame of 720 such lines, then a `vsync` rise -> `frame_start` pulses once and `v_active` = 720.
REQ-040 Island (8 preamble cycles 0101, 2 `dgb`, 64 island cycles, 2 `dgb`) -> `di_active` high for 64 cycles, `hdmi_mode` = 1, and no `err`.
REQ-041 Preamble of 5 cycles then `vgb0` -> `err` pulses once, state = CTRL, and `h_active` is unchanged.
REQ-042 Island of 40 cycles -> `err` pulses at trailing guard-band entry and `hdmi_mode` stays 0.
REQ-043 `all_rdy` dropped mid-VIDEO at pixel 500 -> `vid_active` = 0 next cycle, `h_active` holds its prior value, and the next full line latches the correct width.

Source files
------------

// File: rtl/hdmi_period_tracker.sv
// hdmi_period_tracker: follows the HDMI control / preamble / guard-band /
// video / data-island sequence seen on the three decoded TMDS channels,
// measures the active video geometry and pulses err on protocol violations.
module hdmi_period_tracker #(
    parameter int PRE_LEN = 8,
    parameter int CNT_W   = 12
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic             all_rdy,
    input  logic             de0,
    input  logic             de1,
    input  logic             de2,
    input  logic             c0_0,
    input  logic             c1_0,
    input  logic             c0_1,
    input  logic             c1_1,
    input  logic             c0_2,
    input  logic             c1_2,
    input  logic             ctl_vld1,
    input  logic             ctl_vld2,
    input  logic             vgb0,
    input  logic             dgb1,
    input  logic             dgb2,
    output logic             hsync,
    output logic             vsync,
    output logic             vid_active,
    output logic             di_active,
    output logic             hdmi_mode,
    output logic             frame_start,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_active,
    output logic             err
);

    localparam int               PRE_W    = $clog2(PRE_LEN + 1);
    localparam logic [PRE_W-1:0] PRE_FULL = PRE_W'(PRE_LEN);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ISL_MASK = CNT_W'(31);

    typedef enum logic [2:0] {
        S_CTRL, S_PRE_V, S_PRE_D, S_VGB, S_VIDEO, S_DGB_L, S_ISLAND, S_DGB_T
    } state_t;

    // Saturating increment shared by the pixel, line and island counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       gb_q, gb_d;
    logic [CNT_W-1:0] pix_q, pix_d, isl_q, isl_d, line_q, line_d;
    logic [CNT_W-1:0] h_act_q, h_act_d, v_act_q, v_act_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             vid_q, vid_d, di_q, di_d, hdmi_q, hdmi_d;
    logic             fs_q, fs_d, err_q, err_d;

    logic [3:0] ctl_bits_s;
    logic       tok_s, pre_vid_s, pre_isl_s, de_all_s, dgb_s, isl_ok_s;

    assign ctl_bits_s = {c1_2, c0_2, c1_1, c0_1};
    assign tok_s      = ctl_vld1 & ctl_vld2;
    assign pre_vid_s  = tok_s & (ctl_bits_s == 4'b0001);
    assign pre_isl_s  = tok_s & (ctl_bits_s == 4'b0101);
    assign de_all_s   = de0 & de1 & de2;
    assign dgb_s      = dgb1 & dgb2;
    // A legal island is a whole, nonzero number of 32-pixel packets.
    assign isl_ok_s   = (isl_q != CNT_ZERO) && ((isl_q & ISL_MASK) == CNT_ZERO);

    // Next-state logic for the period FSM, counters and all outputs.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        gb_d    = gb_q;
        pix_d   = pix_q;
        isl_d   = isl_q;
        line_d  = line_q;
        h_act_d = h_act_q;
        v_act_d = v_act_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        hdmi_d  = hdmi_q;
        err_d   = 1'b0;
        fs_d    = 1'b0;
        if (!all_rdy) begin
            // Link lost: restart tracking but keep the last sync levels and geometry.
            state_d = S_CTRL;
            pre_d   = PRE_ZERO;
            gb_d    = 2'd0;
            pix_d   = CNT_ZERO;
            isl_d   = CNT_ZERO;
            line_d  = CNT_ZERO;
            hdmi_d  = 1'b0;
        end else begin
            if (!de0) begin
                hsync_d = c0_0;
                vsync_d = c1_0;
            end else begin
                hsync_d = hsync_q;
                vsync_d = vsync_q;
            end
            case (state_q)
                S_CTRL: begin
                    if (pre_vid_s) begin
                        state_d = S_PRE_V;
                        pre_d   = PRE_ONE;
                    end else if (pre_isl_s) begin
                        state_d = S_PRE_D;
                        pre_d   = PRE_ONE;
                    end else begin
                        state_d = S_CTRL;
                    end
                end
                S_PRE_V: begin
                    if (vgb0) begin
                        if (pre_q >= PRE_FULL) begin
                            state_d = S_VGB;
                            gb_d    = 2'd1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_CTRL;
                        end
                    end else if (pre_vid_s) begin
                        if (pre_q < PRE_FULL) begin
                            pre_d = pre_q + PRE_ONE;
                        end else begin
                            pre_d = pre_q;
                        end
                    end else if (pre_isl_s) begin
                        state_d = S_PRE_D;
                        pre_d   = PRE_ONE;
                    end else begin
                        state_d = S_CTRL;
                    end
                end
                S_PRE_D: begin
                    if (dgb_s) begin
                        if (pre_q >= PRE_FULL) begin
                            state_d = S_DGB_L;
                            gb_d    = 2'd1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_CTRL;
                        end
                    end else if (pre_isl_s) begin
                        if (pre_q < PRE_FULL) begin
                            pre_d = pre_q + PRE_ONE;
                        end else begin
                            pre_d = pre_q;
                        end
                    end else if (pre_vid_s) begin
                        state_d = S_PRE_V;
                        pre_d   = PRE_ONE;
                    end else begin
                        state_d = S_CTRL;
                    end
                end
                S_VGB: begin
                    if (gb_q == 2'd1) begin
                        if (vgb0) begin
                            gb_d = 2'd2;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_CTRL;
                        end
                    end else if (de_all_s && !vgb0) begin
                        // The first video pixel arrives on the cycle after the guard band.
                        state_d = S_VIDEO;
                        pix_d   = CNT_ONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_CTRL;
                    end
                end
                S_VIDEO: begin
                    if (de_all_s) begin
                        pix_d = sat_inc(pix_q);
                    end else begin
                        h_act_d = pix_q;
                        line_d  = sat_inc(line_q);
                        pix_d   = CNT_ZERO;
                        state_d = S_CTRL;
                    end
                end
                S_DGB_L: begin
                    if (gb_q == 2'd1) begin
                        if (dgb_s) begin
                            gb_d = 2'd2;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_CTRL;
                        end
                    end else if (dgb_s) begin
                        err_d   = 1'b1;
                        state_d = S_CTRL;
                    end else begin
                        state_d = S_ISLAND;
                        isl_d   = CNT_ONE;
                    end
                end
                S_ISLAND: begin
                    if (dgb_s) begin
                        state_d = S_DGB_T;
                        gb_d    = 2'd1;
                        if (isl_ok_s) begin
                            hdmi_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        isl_d = sat_inc(isl_q);
                    end
                end
                S_DGB_T: begin
                    if (gb_q == 2'd1) begin
                        if (dgb_s) begin
                            gb_d = 2'd2;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_CTRL;
                        end
                    end else if (dgb_s) begin
                        err_d   = 1'b1;
                        state_d = S_CTRL;
                    end else begin
                        state_d = S_CTRL;
                    end
                end
                default: begin
                    state_d = S_CTRL;
                end
            endcase
            // A line ending in this cycle is already in line_d, so it lands in v_active.
            if (vsync_d && !vsync_q) begin
                fs_d    = 1'b1;
                v_act_d = line_d;
                line_d  = CNT_ZERO;
            end else begin
                fs_d = 1'b0;
            end
        end
        vid_d = (state_d == S_VIDEO);
        di_d  = (state_d == S_ISLAND);
    end

    // State, counters and every output register.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_CTRL;
            pre_q   <= PRE_ZERO;
            gb_q    <= 2'd0;
            pix_q   <= CNT_ZERO;
            isl_q   <= CNT_ZERO;
            line_q  <= CNT_ZERO;
            h_act_q <= CNT_ZERO;
            v_act_q <= CNT_ZERO;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            vid_q   <= 1'b0;
            di_q    <= 1'b0;
            hdmi_q  <= 1'b0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            gb_q    <= gb_d;
            pix_q   <= pix_d;
            isl_q   <= isl_d;
            line_q  <= line_d;
            h_act_q <= h_act_d;
            v_act_q <= v_act_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            vid_q   <= vid_d;
            di_q    <= di_d;
            hdmi_q  <= hdmi_d;
            fs_q    <= fs_d;
            err_q   <= err_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vid_active  = vid_q;
    assign di_active   = di_q;
    assign hdmi_mode   = hdmi_q;
    assign frame_start = fs_q;
    assign h_active    = h_act_q;
    assign v_active    = v_act_q;
    assign err         = err_q;

endmodule

// File: tb/tb_hdmi_period_tracker.sv
// Self-checking bench for hdmi_period_tracker: stimulus is built from whole
// HDMI periods (video lines, data islands, frame syncs, link drops) whose
// expected outputs follow from the period rules; a compare process checks
// every output on every cycle.
module tb_hdmi_period_tracker;

    localparam int PRE_LEN = 8;
    localparam int CNT_W   = 12;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef enum int {K_IDLE, K_PRE_V, K_PRE_D, K_VGB, K_DGB, K_DATA, K_ISL} kind_t;

    logic             pclk = 1'b0;
    logic             reset_n, all_rdy, de0, de1, de2, c0_0, c1_0;
    logic             c0_1, c1_1, c0_2, c1_2, ctl_vld1, ctl_vld2, vgb0, dgb1, dgb2;
    logic             hsync, vsync, vid_active, di_active, hdmi_mode, frame_start, err;
    logic [CNT_W-1:0] h_active, v_active;

    hdmi_period_tracker #(.PRE_LEN(PRE_LEN), .CNT_W(CNT_W)) dut (
        .pclk(pclk), .reset_n(reset_n), .all_rdy(all_rdy),
        .de0(de0), .de1(de1), .de2(de2), .c0_0(c0_0), .c1_0(c1_0),
        .c0_1(c0_1), .c1_1(c1_1), .c0_2(c0_2), .c1_2(c1_2),
        .ctl_vld1(ctl_vld1), .ctl_vld2(ctl_vld2),
        .vgb0(vgb0), .dgb1(dgb1), .dgb2(dgb2),
        .hsync(hsync), .vsync(vsync), .vid_active(vid_active), .di_active(di_active),
        .hdmi_mode(hdmi_mode), .frame_start(frame_start),
        .h_active(h_active), .v_active(v_active), .err(err)
    );

    always #5 pclk = ~pclk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: what the outputs must be after the current edge.
    bit m_hs, m_vs, m_hdmi, x_vid, x_di, x_err, x_fs;
    int m_line, m_hact, m_vact;
    bit cur_vs;
    bit chk_en = 1'b0;
    int err_seen, fs_seen, vid_seen, di_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single per-cycle compare process, sampling 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge pclk);
            #1;
            if (chk_en) begin
                check("hsync", hsync, m_hs);
                check("vsync", vsync, m_vs);
                check("vid_active", vid_active, x_vid);
                check("di_active", di_active, x_di);
                check("hdmi_mode", hdmi_mode, m_hdmi);
                check("frame_start", frame_start, x_fs);
                check("err", err, x_err);
                check("h_active", h_active, m_hact);
                check("v_active", v_active, m_vact);
                if (err === 1'b1) err_seen++;
                if (frame_start === 1'b1) fs_seen++;
                if (vid_active === 1'b1) vid_seen++;
                if (di_active === 1'b1) di_seen++;
            end
        end
    end

    // Drive one cycle of a given kind and record what the outputs must become.
    task automatic step(input kind_t k, input bit rdy, input bit e_vid, input bit e_di,
                        input bit e_err, input int lend, input bit hset);
        bit hs;
        bit prev_vs;
        @(negedge pclk);
        hs       = 1'($urandom_range(0, 1));
        all_rdy  = rdy;
        de0      = (k == K_DATA);
        de1      = (k == K_DATA);
        de2      = (k == K_DATA);
        c0_0     = hs;
        c1_0     = cur_vs;
        c0_1     = (k == K_PRE_V) || (k == K_PRE_D);
        c1_1     = 1'b0;
        c0_2     = (k == K_PRE_D);
        c1_2     = 1'b0;
        ctl_vld1 = (k == K_IDLE) || (k == K_PRE_V) || (k == K_PRE_D);
        ctl_vld2 = ctl_vld1;
        vgb0     = (k == K_VGB);
        dgb1     = (k == K_DGB);
        dgb2     = (k == K_DGB);
        x_fs     = 1'b0;
        if (rdy) begin
            prev_vs = m_vs;
            if (k != K_DATA) begin
                m_hs = hs;
                m_vs = cur_vs;
            end
            if (lend >= 0) begin
                m_hact = (lend > CNT_MAX) ? CNT_MAX : lend;
                m_line = (m_line >= CNT_MAX) ? CNT_MAX : m_line + 1;
            end
            if (hset) m_hdmi = 1'b1;
            if (m_vs && !prev_vs) begin
                x_fs   = 1'b1;
                m_vact = m_line;
                m_line = 0;
            end
            x_vid = e_vid;
            x_di  = e_di;
            x_err = e_err;
        end else begin
            m_line = 0;
            m_hdmi = 1'b0;
            x_vid  = 1'b0;
            x_di   = 1'b0;
            x_err  = 1'b0;
        end
        chk_en = 1'b1;
    endtask

    task automatic nop(input kind_t k);
        step(k, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic settle();
        @(posedge pclk);
        #2;
    endtask

    task automatic clear_seen();
        err_seen = 0; fs_seen = 0; vid_seen = 0; di_seen = 0;
    endtask

    task automatic do_reset();
        chk_en  = 1'b0;
        reset_n = 1'b0;
        all_rdy = 1'b1; de0 = 1'b0; de1 = 1'b0; de2 = 1'b0; c0_0 = 1'b0; c1_0 = 1'b0;
        c0_1 = 1'b0; c1_1 = 1'b0; c0_2 = 1'b0; c1_2 = 1'b0;
        ctl_vld1 = 1'b1; ctl_vld2 = 1'b1; vgb0 = 1'b0; dgb1 = 1'b0; dgb2 = 1'b0;
        cur_vs = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_hdmi = 1'b0;
        m_line = 0; m_hact = 0; m_vact = 0;
        x_vid = 1'b0; x_di = 1'b0; x_err = 1'b0; x_fs = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_vid", vid_active, 0);
        check("rst_di", di_active, 0);
        check("rst_hdmi", hdmi_mode, 0);
        check("rst_fs", frame_start, 0);
        check("rst_err", err, 0);
        check("rst_hact", h_active, 0);
        check("rst_vact", v_active, 0);
        reset_n = 1'b1;
    endtask

    // Video line: preamble (optionally led by island preamble), guard band, pixels, control.
    task automatic video_line(input int npre, input int nother, input int ngb,
                              input int ndata, input bit vs_end);
        bit dead = 1'b0;
        bit pend = 1'b0;
        bit ok;
        for (int i = 0; i < nother; i++) nop(K_PRE_D);
        for (int i = 0; i < npre; i++) nop(K_PRE_V);
        for (int i = 0; i < ngb; i++) begin
            bit e;
            e = !dead && ((i == 0 && npre < PRE_LEN) || i == 2);
            if (e) dead = 1'b1;
            step(K_VGB, 1'b1, 1'b0, 1'b0, e, -1, 1'b0);
        end
        if (!dead && ngb == 1) pend = 1'b1;
        ok = !dead && (ngb == 2);
        for (int i = 0; i < ndata; i++) begin
            step(K_DATA, 1'b1, ok, 1'b0, pend && i == 0, -1, 1'b0);
        end
        cur_vs = vs_end;
        step(K_IDLE, 1'b1, 1'b0, 1'b0, pend && ndata == 0, ok ? ndata : -1, 1'b0);
        nop(K_IDLE);
    endtask

    // Data island: preamble, leading guard band, island body, trailing guard band.
    task automatic island(input int npre, input int nother, input int ngbl,
                          input int nisl, input int ngbt);
        bit dead = 1'b0;
        bit pend = 1'b0;
        bit ok;
        for (int i = 0; i < nother; i++) nop(K_PRE_V);
        for (int i = 0; i < npre; i++) nop(K_PRE_D);
        for (int i = 0; i < ngbl; i++) begin
            bit e;
            e = !dead && ((i == 0 && npre < PRE_LEN) || i == 2);
            if (e) dead = 1'b1;
            step(K_DGB, 1'b1, 1'b0, 1'b0, e, -1, 1'b0);
        end
        if (!dead && ngbl == 1) pend = 1'b1;
        ok = !dead && (ngbl == 2);
        for (int i = 0; i < nisl; i++) begin
            step(K_ISL, 1'b1, 1'b0, ok, pend && i == 0, -1, 1'b0);
        end
        for (int i = 0; i < ngbt; i++) begin
            bit e = 1'b0;
            bit hs = 1'b0;
            if (ok && i == 0) begin
                if (nisl % 32 != 0) e = 1'b1;
                else hs = 1'b1;
            end else if (ok && i == 2) begin
                e = 1'b1;
            end
            step(K_DGB, 1'b1, 1'b0, 1'b0, e, -1, hs);
        end
        step(K_IDLE, 1'b1, 1'b0, 1'b0, ok && ngbt == 1, -1, 1'b0);
        nop(K_IDLE);
    endtask

    // Good video line cut by a one-cycle link drop after k pixels.
    task automatic video_drop(input int k, input int rest);
        for (int i = 0; i < PRE_LEN; i++) nop(K_PRE_V);
        nop(K_VGB);
        nop(K_VGB);
        for (int i = 0; i < k; i++) step(K_DATA, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        step(K_DATA, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        for (int i = 0; i < rest; i++) nop(K_DATA);
        nop(K_IDLE);
        nop(K_IDLE);
    endtask

    task automatic frame_pulse(input int nhi);
        cur_vs = 1'b1;
        repeat (nhi) nop(K_IDLE);
        cur_vs = 1'b0;
        repeat (2) nop(K_IDLE);
    endtask

    function automatic int pick_gb();
        int r;
        r = $urandom_range(0, 5);
        return (r == 0) ? 1 : ((r == 1) ? 3 : 2);
    endfunction

    initial begin
        do_reset();
        clear_seen();

        // 1280-pixel line.
        video_line(PRE_LEN, 0, 2, 1280, 1'b0);
        settle();
        check("line1280_hact", h_active, 1280);
        check("line1280_vidcnt", vid_seen, 1280);
        check("line1280_err", err_seen, 0);
        frame_pulse(3);
        settle();
        check("first_frame_vact", v_active, 1);

        // 720-line frame.
        clear_seen();
        repeat (720) video_line(PRE_LEN, 0, 2, 16, 1'b0);
        frame_pulse(3);
        settle();
        check("frame720_vact", v_active, 720);
        check("frame720_fs", fs_seen, 1);
        check("frame720_hact", h_active, 16);

        // Legal 64-cycle island.
        clear_seen();
        island(PRE_LEN, 0, 2, 64, 2);
        settle();
        check("isl64_hdmi", hdmi_mode, 1);
        check("isl64_dicnt", di_seen, 64);
        check("isl64_err", err_seen, 0);

        // Short preamble before video guard band.
        clear_seen();
        video_line(5, 0, 2, 20, 1'b0);
        settle();
        check("pre5_err", err_seen, 1);
        check("pre5_vid", vid_seen, 0);
        check("pre5_hact", h_active, 16);

        // 40-cycle island after a link drop cleared hdmi_mode.
        step(K_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        clear_seen();
        island(PRE_LEN, 0, 2, 40, 2);
        settle();
        check("isl40_err", err_seen, 1);
        check("isl40_hdmi", hdmi_mode, 0);

        // Link drop at pixel 500, then a full line.
        clear_seen();
        video_drop(500, 3);
        settle();
        check("drop_vidcnt", vid_seen, 500);
        check("drop_hact", h_active, 16);
        video_line(PRE_LEN, 0, 2, 700, 1'b0);
        settle();
        check("after_drop_hact", h_active, 700);

        // Line end coinciding with the vsync rise.
        frame_pulse(2);
        clear_seen();
        repeat (3) video_line(PRE_LEN, 0, 2, 10, 1'b0);
        video_line(PRE_LEN, 0, 2, 10, 1'b1);
        settle();
        check("coincide_vact", v_active, 4);
        check("coincide_fs", fs_seen, 1);
        cur_vs = 1'b0;
        nop(K_IDLE);

        // Pixel counter saturation and preamble pattern restarts.
        video_line(PRE_LEN, 0, 2, 4100, 1'b0);
        settle();
        check("sat_hact", h_active, CNT_MAX);
        clear_seen();
        video_line(PRE_LEN, 4, 2, 12, 1'b0);
        video_line(5, 5, 2, 20, 1'b0);
        settle();
        check("restart_hact", h_active, 12);
        check("restart_err", err_seen, 1);

        // Randomized period mix.
        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                video_line($urandom_range(1, 11), $urandom_range(0, 3), pick_gb(),
                           $urandom_range(1, 40), ($urandom_range(0, 7) == 0));
            end else if (r <= 6) begin
                island($urandom_range(1, 11), $urandom_range(0, 3), pick_gb(),
                       ($urandom_range(0, 1) == 1) ? 32 * $urandom_range(1, 3) : $urandom_range(1, 100),
                       pick_gb());
            end else if (r == 7) begin
                frame_pulse($urandom_range(1, 4));
            end else if (r == 8) begin
                video_drop($urandom_range(1, 30), $urandom_range(0, 5));
            end else begin
                step(K_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
                repeat ($urandom_range(1, 3)) nop(K_IDLE);
            end
        end

        // Reset in the middle of a line.
        for (int i = 0; i < PRE_LEN; i++) nop(K_PRE_V);
        nop(K_VGB);
        nop(K_VGB);
        repeat (50) step(K_DATA, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        do_reset();
        clear_seen();
        repeat (3) nop(K_IDLE);
        video_line(PRE_LEN, 0, 2, 33, 1'b0);
        settle();
        check("post_rst_hact", h_active, 33);
        check("post_rst_err", err_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
